bus_test_monitor: RTL and testbench
===================================

BUS_TEST_MONITOR -- requirements
Module: bus_test_monitor

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, bus address width.
REQ-002 SHALL have parameter DATA_W, default 32, bus data width (multiple of 8).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0001_FFF0, first magic address; channel i decodes at BASE_ADDR + 4*i.
REQ-004 SHALL have parameter N_CH, default 4, number of magic channels (2..8); channel 0 = status, channel 1 = heartbeat, channels 2..N_CH-1 = scratch capture.
REQ-005 SHALL have parameters PASS_CODE, default 32'h1, and FAIL_CODE, default 32'hDEAD_BEEF.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 50000, cycle budget; parameter WDOG_MODE, default 0 (0 = absolute budget, 1 = watchdog restarted by heartbeat).
REQ-007 SHALL have ports: clk in 1 clock; rst in 1 synchronous active-low reset.
REQ-008 SHALL have ports: bus_addr in ADDR_W; bus_wdata in DATA_W; dmem_we in DATA_W/8 byte enables; dmem_ce in 1 data-memory chip enable.
REQ-009 SHALL have ports: pc in 32 current PC; fetch_strobe in 1, high one cycle per instruction fetch.
REQ-010 SHALL have ports: done out 1; pass out 1; fail out 1; timeout out 1; done_pulse out 1.
REQ-011 SHALL have ports: end_pc out 32 PC at terminal event; cycle_count out 32; instr_count out 32; scratch out (N_CH-2)*DATA_W, channel 2 in the LSBs.

Function
REQ-012 Only clk SHALL be used; all outputs SHALL be registered.
REQ-013 A write SHALL be defined as dmem_ce=1 and dmem_we all ones at a rising edge; partial-byte writes SHALL be ignored by every channel.
REQ-014 FSM states SHALL be IDLE, RUN, PASS, FAIL, TMO; IDLE -> RUN on the first fetch_strobe.
REQ-015 Channel 0 write of PASS_CODE SHALL move IDLE or RUN to PASS; FAIL_CODE SHALL move to FAIL; other values SHALL be ignored.
REQ-016 In RUN, when the timeout counter reaches TIMEOUT_CYCLES-1 the FSM SHALL move to TMO.
REQ-017 Timeout counter SHALL clear on entry to RUN, increment each RUN cycle; in WDOG_MODE=1 any channel 1 write SHALL also clear it, with the clear beating the increment in that cycle.
REQ-018 Channel 0 PASS/FAIL write SHALL have priority over timeout expiry in the same cycle.
REQ-019 PASS, FAIL, TMO SHALL be terminal and sticky until reset; later bus writes SHALL change no output.
REQ-020 done SHALL equal (PASS or FAIL or TMO); pass, fail, timeout SHALL be one-hot in their states; outputs SHALL assert the cycle after the deciding edge.
REQ-021 done_pulse SHALL be high exactly one cycle, coincident with the first cycle done is high.
REQ-022 end_pc SHALL capture pc at the deciding edge.
REQ-023 cycle_count SHALL increment each non-IDLE, non-terminal cycle, saturating at 32'hFFFF_FFFF.
REQ-024 instr_count SHALL increment on each fetch_strobe while not terminal (including the IDLE->RUN fetch), saturating.
REQ-025 Scratch channel i SHALL load bus_wdata on a write to its address while not terminal; writes outside BASE_ADDR..BASE_ADDR+4*N_CH-4 or unaligned SHALL be ignored.

Reset
REQ-026 rst=0 at a rising edge SHALL force IDLE and clear all outputs, counters and scratch to 0, regardless of current state, including terminal states.
REQ-027 A bus write coincident with rst=0 SHALL be discarded.

Verification
REQ-028 Reset, 10 fetch_strobes, write 32'h1 to 0x0001_FFF0 -> next cycle pass=1, done=1, done_pulse=1 one cycle, instr_count=10, end_pc=pc at write.
REQ-029 Write 32'hDEAD_BEEF to 0x0001_FFF0 then 32'h1 -> fail=1 stays, pass never asserts.
REQ-030 TIMEOUT_CYCLES=100, WDOG_MODE=0, fetch then no status write -> timeout=1 exactly 100 cycles after RUN entry.
REQ-031 WDOG_MODE=1, TIMEOUT_CYCLES=100, heartbeat write to 0x0001_FFF4 every 60 cycles for 1000 cycles -> timeout stays 0; stop heartbeats -> timeout 100 cycles after last.
REQ-032 Write 32'hCAFE_0001 to 0x0001_FFF8 with dmem_we=4'b1111, then 32'h0 with dmem_we=4'b0011 -> scratch[31:0]=32'hCAFE_0001.
REQ-033 Assert rst=0 one cycle while in PASS -> all outputs 0, state IDLE; status write and expiry in same cycle -> status wins.

Source files
------------

// File: rtl/bus_test_monitor.sv
// Self-test monitor for a CPU under test: decodes magic-address stores into a
// pass/fail/timeout verdict and keeps PC, cycle, instruction and scratch records.
module bus_test_monitor #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = 32'h0001_FFF0,
    parameter int                N_CH           = 4,
    parameter logic [DATA_W-1:0] PASS_CODE      = 32'h0000_0001,
    parameter logic [DATA_W-1:0] FAIL_CODE      = 32'hDEAD_BEEF,
    parameter int                TIMEOUT_CYCLES = 50000,
    parameter int                WDOG_MODE      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          bus_addr,
    input  logic [DATA_W-1:0]          bus_wdata,
    input  logic [DATA_W/8-1:0]        dmem_we,
    input  logic                       dmem_ce,
    input  logic [31:0]                pc,
    input  logic                       fetch_strobe,
    output logic                       done,
    output logic                       pass,
    output logic                       fail,
    output logic                       timeout,
    output logic                       done_pulse,
    output logic [31:0]                end_pc,
    output logic [31:0]                cycle_count,
    output logic [31:0]                instr_count,
    output logic [(N_CH-2)*DATA_W-1:0] scratch
);

    localparam int                NB        = DATA_W / 8;
    localparam int                SCR_W     = (N_CH - 2) * DATA_W;
    localparam logic [31:0]       TMO_LIMIT = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] SPAN      = ADDR_W'(4 * N_CH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_PASS = 3'd2,
        S_FAIL = 3'd3,
        S_TMO  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       tmo_cnt_q, tmo_cnt_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              timeout_q, timeout_d;
    logic              done_pulse_q, done_pulse_d;
    logic [31:0]       end_pc_q, end_pc_d;
    logic [31:0]       cycle_count_q, cycle_count_d;
    logic [31:0]       instr_count_q, instr_count_d;
    logic [SCR_W-1:0]  scratch_q, scratch_d;

    logic              is_write;
    logic [ADDR_W-1:0] offset;
    logic              hit;
    logic [2:0]        ch;
    logic              status_wr;
    logic              hb_wr;
    logic              terminal;
    logic              terminal_next;
    logic              enter_term;

    // Unsigned offset wraps for addresses below the base, so one compare covers both range ends.
    assign is_write  = dmem_ce && (dmem_we == {NB{1'b1}});
    assign offset    = bus_addr - BASE_ADDR;
    assign hit       = is_write && (offset < SPAN) && (offset[1:0] == 2'b00);
    assign ch        = offset[4:2];
    assign status_wr = hit && (ch == 3'd0);
    assign hb_wr     = hit && (ch == 3'd1);
    assign terminal  = (state_q == S_PASS) || (state_q == S_FAIL) || (state_q == S_TMO);

    // Next-state logic; a status write outranks timeout expiry in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (status_wr && (bus_wdata == PASS_CODE)) begin
                    state_d = S_PASS;
                end else if (status_wr && (bus_wdata == FAIL_CODE)) begin
                    state_d = S_FAIL;
                end else if (fetch_strobe) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (status_wr && (bus_wdata == PASS_CODE)) begin
                    state_d = S_PASS;
                end else if (status_wr && (bus_wdata == FAIL_CODE)) begin
                    state_d = S_FAIL;
                end else if ((tmo_cnt_q == TMO_LIMIT) && !((WDOG_MODE == 1) && hb_wr)) begin
                    state_d = S_TMO;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_PASS:  state_d = S_PASS;
            S_FAIL:  state_d = S_FAIL;
            S_TMO:   state_d = S_TMO;
            default: state_d = S_IDLE;
        endcase
    end

    // Counters, verdict outputs and scratch capture, all computed from the next state.
    always_comb begin
        terminal_next = (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TMO);
        enter_term    = !terminal && terminal_next;

        if (state_q == S_RUN) begin
            if ((WDOG_MODE == 1) && hb_wr) begin
                tmo_cnt_d = 32'd0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 32'd1;
            end
        end else if (state_q == S_IDLE) begin
            tmo_cnt_d = 32'd0;
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end

        done_d       = terminal_next;
        pass_d       = (state_d == S_PASS);
        fail_d       = (state_d == S_FAIL);
        timeout_d    = (state_d == S_TMO);
        done_pulse_d = enter_term;

        if (enter_term) begin
            end_pc_d = pc;
        end else begin
            end_pc_d = end_pc_q;
        end

        if ((state_q == S_RUN) && (cycle_count_q != 32'hFFFF_FFFF)) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end else begin
            cycle_count_d = cycle_count_q;
        end

        if (!terminal && fetch_strobe && (instr_count_q != 32'hFFFF_FFFF)) begin
            instr_count_d = instr_count_q + 32'd1;
        end else begin
            instr_count_d = instr_count_q;
        end

        scratch_d = scratch_q;
        for (int i = 2; i < N_CH; i++) begin
            if (!terminal && hit && (ch == 3'(i))) begin
                scratch_d[(i-2)*DATA_W +: DATA_W] = bus_wdata;
            end else begin
                scratch_d[(i-2)*DATA_W +: DATA_W] = scratch_q[(i-2)*DATA_W +: DATA_W];
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            tmo_cnt_q     <= 32'd0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
            done_pulse_q  <= 1'b0;
            end_pc_q      <= 32'd0;
            cycle_count_q <= 32'd0;
            instr_count_q <= 32'd0;
            scratch_q     <= '0;
        end else begin
            state_q       <= state_d;
            tmo_cnt_q     <= tmo_cnt_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            timeout_q     <= timeout_d;
            done_pulse_q  <= done_pulse_d;
            end_pc_q      <= end_pc_d;
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
            scratch_q     <= scratch_d;
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign done_pulse  = done_pulse_q;
    assign end_pc      = end_pc_q;
    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;
    assign scratch     = scratch_q;

endmodule

// File: tb/tb_bus_test_monitor.sv
// Bench for bus_test_monitor: two instances (absolute budget and watchdog) share
// one stimulus stream and are checked against a cycle-level verdict model.
module tb_bus_test_monitor;

    localparam int          N_CH = 4;
    localparam int          T    = 100;
    localparam logic [31:0] BASE = 32'h0001_FFF0;
    localparam logic [31:0] PASS = 32'h0000_0001;
    localparam logic [31:0] FAILC = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bus_addr, bus_wdata, pc;
    logic [3:0]  dmem_we;
    logic        dmem_ce, fetch_strobe;

    logic [1:0]        o_done, o_pass, o_fail, o_tmo, o_pulse;
    logic [1:0][31:0]  o_end_pc, o_cycles, o_instr;
    logic [1:0][63:0]  o_scr;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    logic [31:0] last_pc;

    // Model: verdict 0 none, 1 pass, 2 fail, 3 timeout; restart = edge index of the last budget restart.
    int          m_verdict [2];
    bit          m_started [2];
    int          m_restart [2];
    logic [31:0] m_instr   [2];
    logic [31:0] m_cycles  [2];
    logic [31:0] m_endpc   [2];
    bit          m_pulse   [2];
    logic [31:0] m_scr     [2][2];

    always #5 clk = ~clk;

    bus_test_monitor #(.BASE_ADDR(BASE), .N_CH(N_CH), .TIMEOUT_CYCLES(T), .WDOG_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .dmem_we(dmem_we),
        .dmem_ce(dmem_ce), .pc(pc), .fetch_strobe(fetch_strobe), .done(o_done[0]), .pass(o_pass[0]),
        .fail(o_fail[0]), .timeout(o_tmo[0]), .done_pulse(o_pulse[0]), .end_pc(o_end_pc[0]),
        .cycle_count(o_cycles[0]), .instr_count(o_instr[0]), .scratch(o_scr[0]));

    bus_test_monitor #(.BASE_ADDR(BASE), .N_CH(N_CH), .TIMEOUT_CYCLES(T), .WDOG_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .dmem_we(dmem_we),
        .dmem_ce(dmem_ce), .pc(pc), .fetch_strobe(fetch_strobe), .done(o_done[1]), .pass(o_pass[1]),
        .fail(o_fail[1]), .timeout(o_tmo[1]), .done_pulse(o_pulse[1]), .end_pc(o_end_pc[1]),
        .cycle_count(o_cycles[1]), .instr_count(o_instr[1]), .scratch(o_scr[1]));

    task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic model_step(input int k);
        bit is_wr;
        int ch;
        m_pulse[k] = 1'b0;
        if (!rst) begin
            m_verdict[k] = 0;
            m_started[k] = 1'b0;
            m_restart[k] = 0;
            m_instr[k]   = 32'd0;
            m_cycles[k]  = 32'd0;
            m_endpc[k]   = 32'd0;
            m_scr[k][0]  = 32'd0;
            m_scr[k][1]  = 32'd0;
        end else if (m_verdict[k] == 0) begin
            is_wr = dmem_ce && (dmem_we == 4'hF);
            ch = -1;
            if (is_wr && bus_addr >= BASE && bus_addr < BASE + 32'(4 * N_CH) && bus_addr[1:0] == 2'b00)
                ch = int'((bus_addr - BASE) >> 2);
            if (fetch_strobe && m_instr[k] != 32'hFFFF_FFFF) m_instr[k] = m_instr[k] + 32'd1;
            if (m_started[k] && m_cycles[k] != 32'hFFFF_FFFF) m_cycles[k] = m_cycles[k] + 32'd1;
            if (ch >= 2) m_scr[k][ch-2] = bus_wdata;
            if (ch == 0 && bus_wdata == PASS) m_verdict[k] = 1;
            else if (ch == 0 && bus_wdata == FAILC) m_verdict[k] = 2;
            else if (!m_started[k]) begin
                if (fetch_strobe) begin
                    m_started[k] = 1'b1;
                    m_restart[k] = edge_n;
                end
            end
            else if (k == 1 && ch == 1) m_restart[k] = edge_n;
            else if (edge_n - m_restart[k] == T) m_verdict[k] = 3;
            if (m_verdict[k] != 0) begin
                m_pulse[k] = 1'b1;
                m_endpc[k] = pc;
            end
        end
    endtask

    task automatic tick();
        pc = $urandom;
        last_pc = pc;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        edge_n++;
        for (int k = 0; k < 2; k++) begin
            chk("done", k, 64'(o_done[k]), 64'(m_verdict[k] != 0));
            chk("pass", k, 64'(o_pass[k]), 64'(m_verdict[k] == 1));
            chk("fail", k, 64'(o_fail[k]), 64'(m_verdict[k] == 2));
            chk("timeout", k, 64'(o_tmo[k]), 64'(m_verdict[k] == 3));
            chk("done_pulse", k, 64'(o_pulse[k]), 64'(m_pulse[k]));
            chk("end_pc", k, 64'(o_end_pc[k]), 64'(m_endpc[k]));
            chk("cycle_count", k, 64'(o_cycles[k]), 64'(m_cycles[k]));
            chk("instr_count", k, 64'(o_instr[k]), 64'(m_instr[k]));
            chk("scratch", k, o_scr[k], {m_scr[k][1], m_scr[k][0]});
        end
    endtask

    task automatic drive_idle();
        dmem_ce = 1'b0;
        dmem_we = 4'h0;
        fetch_strobe = 1'b0;
        bus_addr = 32'h0;
        bus_wdata = 32'h0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        bus_addr = a;
        bus_wdata = d;
        dmem_we = we;
        dmem_ce = 1'b1;
        tick();
        drive_idle();
    endtask

    task automatic fetch1();
        fetch_strobe = 1'b1;
        tick();
        fetch_strobe = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] pass_pc;
        drive_idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        chk("reset_done", 0, 64'(o_done[0]), 64'd0);

        // Ten fetches with idle gaps and a stray out-of-range store, then PASS.
        for (int i = 0; i < 10; i++) begin
            fetch1();
            if (i % 3 == 0) bus_write(32'h0002_0000, PASS, 4'hF);
        end
        bus_write(BASE, PASS, 4'hF);
        pass_pc = last_pc;
        chk("req028_pass", 0, 64'(o_pass[0]), 64'd1);
        chk("req028_pulse", 0, 64'(o_pulse[0]), 64'd1);
        chk("req028_instr", 0, 64'(o_instr[0]), 64'd10);
        chk("req028_end_pc", 0, 64'(o_end_pc[0]), 64'(pass_pc));
        tick();
        chk("req028_pulse_once", 0, 64'(o_pulse[0]), 64'd0);
        bus_write(BASE, FAILC, 4'hF);
        bus_write(BASE + 32'd8, 32'h1234_5678, 4'hF);
        fetch1();
        chk("sticky_pass", 0, 64'(o_pass[0]), 64'd1);

        // Reset out of PASS, with a scratch write discarded by the reset.
        bus_addr = BASE + 32'd12; bus_wdata = 32'h5555_AAAA; dmem_we = 4'hF; dmem_ce = 1'b1;
        do_reset();
        drive_idle();
        chk("req033_reset_pass", 0, 64'(o_pass[0]), 64'd0);
        chk("req027_scratch", 0, o_scr[0], 64'd0);

        // FAIL is sticky against a later PASS.
        fetch1();
        bus_write(BASE, FAILC, 4'hF);
        bus_write(BASE, PASS, 4'hF);
        tick();
        chk("req029_fail", 0, 64'(o_fail[0]), 64'd1);
        chk("req029_pass", 0, 64'(o_pass[0]), 64'd0);

        // Scratch capture, partial/unaligned/out-of-range writes, then absolute timeout.
        do_reset();
        fetch1();
        bus_write(BASE + 32'd8, 32'hCAFE_0001, 4'hF);
        bus_write(BASE + 32'd8, 32'h0, 4'b0011);
        bus_write(BASE + 32'd9, 32'h0, 4'hF);
        bus_write(BASE + 32'd16, 32'h0, 4'hF);
        bus_write(BASE - 32'd4, 32'h0, 4'hF);
        chk("req032_scratch", 0, o_scr[0][31:0], 64'h0000_0000_CAFE_0001);
        for (int i = 0; i < T - 1 - 5; i++) tick();
        chk("req030_before", 0, 64'(o_tmo[0]), 64'd0);
        tick();
        chk("req030_at", 0, 64'(o_tmo[0]), 64'd1);

        // Watchdog heartbeats every 60 cycles, then silence.
        do_reset();
        fetch1();
        for (int i = 1; i <= 1000; i++) begin
            if (i % 60 == 0) bus_write(BASE + 32'd4, $urandom, 4'hF);
            else tick();
        end
        chk("req031_alive", 1, 64'(o_tmo[1]), 64'd0);
        chk("req031_abs_expired", 0, 64'(o_tmo[0]), 64'd1);
        for (int i = 0; i < 59; i++) tick();
        chk("req031_before", 1, 64'(o_tmo[1]), 64'd0);
        tick();
        chk("req031_at", 1, 64'(o_tmo[1]), 64'd1);

        // Status write on the expiry edge wins.
        do_reset();
        fetch1();
        for (int i = 0; i < T - 1; i++) tick();
        bus_write(BASE, PASS, 4'hF);
        chk("req033_status_wins", 0, 64'(o_pass[0]), 64'd1);
        chk("req033_no_tmo", 0, 64'(o_tmo[0]), 64'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) != 0);
            fetch_strobe = 1'($urandom);
            dmem_ce = 1'($urandom);
            dmem_we = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
            case ($urandom_range(0, 4))
                0:       bus_addr = $urandom;
                1:       bus_addr = BASE + 32'($urandom_range(0, 24));
                2:       bus_addr = BASE - 32'd4;
                default: bus_addr = BASE + 32'(4 * $urandom_range(0, 3));
            endcase
            case ($urandom_range(0, 99))
                0:       bus_wdata = PASS;
                1:       bus_wdata = FAILC;
                default: bus_wdata = $urandom;
            endcase
            tick();
        end
        rst = 1'b1;
        drive_idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
